// File: rtl/screensaver_ctrl.sv
// Screensaver pixel-path sequencer: bounces a sprite once per frame, maps VGA position to
// sprite ROM addresses aligned to a synchronous ROM, and selects the displayed image.
module screensaver_ctrl #(
  parameter int unsigned IMAGE_WIDTH      = 160,
  parameter int unsigned IMAGE_HEIGHT     = 120,
  parameter int unsigned SCREEN_WIDTH     = 640,
  parameter int unsigned SCREEN_HEIGHT    = 480,
  parameter int unsigned FRAMES_PER_IMAGE = 300,
  parameter int unsigned ROM_AW           = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [9:0]        position_x_i,
  input  logic [9:0]        position_y_i,
  input  logic              visible_i,
  input  logic [3:0]        select_image_i,
  input  logic              pause_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  output logic              sprite_valid_o,
  output logic [3:0]        image_sel_o,
  output logic [9:0]        sprite_x_o,
  output logic [9:0]        sprite_y_o
);

  localparam logic [9:0] XMax = 10'(SCREEN_WIDTH - IMAGE_WIDTH);
  localparam logic [9:0] YMax = 10'(SCREEN_HEIGHT - IMAGE_HEIGHT);
  localparam int unsigned CntW = (FRAMES_PER_IMAGE > 1) ? $clog2(FRAMES_PER_IMAGE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FRAMES_PER_IMAGE - 1);

  logic              r_bottom;
  logic [9:0]        r_x, r_y;
  logic              r_dir_x_neg, r_dir_y_neg;
  logic [CntW-1:0]   r_cnt;
  logic [3:0]        r_sel;
  logic [ROM_AW-1:0] r_addr;
  logic              r_hit, r_valid;

  logic              w_at_bottom, w_tick, w_step;
  logic [10:0]       w_x_next, w_y_next;
  logic [10:0]       w_px, w_py, w_sx, w_sy, w_row, w_col;
  logic              w_hit, w_sel_valid;
  logic [ROM_AW-1:0] w_addr;
  logic [CntW-1:0]   w_cnt_d;
  logic [3:0]        w_sel_d;

  // Returns {dir_neg, pos} after one step, reflecting off 0 and lim.
  function automatic logic [10:0] bounce(input logic [9:0] pos, input logic neg,
                                         input logic [9:0] lim);
    if (!neg && pos == lim)     bounce = {1'b1, lim - 10'd1};
    else if (neg && pos == '0)  bounce = {1'b0, 10'd1};
    else if (neg)               bounce = {1'b1, pos - 10'd1};
    else                        bounce = {1'b0, pos + 10'd1};
  endfunction

  // Tick lands in vertical blanking, so the sprite never moves mid-frame.
  assign w_at_bottom = (position_y_i == 10'(SCREEN_HEIGHT));
  assign w_tick      = w_at_bottom & ~r_bottom;
  assign w_step      = w_tick & ~pause_i;
  assign w_x_next    = bounce(r_x, r_dir_x_neg, XMax);
  assign w_y_next    = bounce(r_y, r_dir_y_neg, YMax);

  assign w_px  = {1'b0, position_x_i};
  assign w_py  = {1'b0, position_y_i};
  assign w_sx  = {1'b0, r_x};
  assign w_sy  = {1'b0, r_y};
  assign w_row = w_py - w_sy;
  assign w_col = w_px - w_sx;
  assign w_hit = visible_i && (w_px >= w_sx) && (w_px < w_sx + 11'(IMAGE_WIDTH)) &&
                 (w_py >= w_sy) && (w_py < w_sy + 11'(IMAGE_HEIGHT));
  assign w_addr = w_hit ? (ROM_AW'(w_row) * ROM_AW'(IMAGE_WIDTH) + ROM_AW'(w_col)) : '0;

  assign w_sel_valid = (select_image_i != 4'b0) &&
                       ((select_image_i & (select_image_i - 4'd1)) == 4'b0);

  always_comb begin
    w_sel_d = r_sel;
    w_cnt_d = r_cnt;
    if (w_sel_valid) begin
      w_sel_d = select_image_i;
      w_cnt_d = '0;
    end else if (select_image_i == 4'b0 && w_step) begin
      if (r_cnt == CntLast) begin
        w_cnt_d = '0;
        w_sel_d = {r_sel[2:0], r_sel[3]};
      end else begin
        w_cnt_d = r_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_bottom    <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_dir_x_neg <= 1'b0;
      r_dir_y_neg <= 1'b0;
      r_cnt       <= '0;
      r_sel       <= 4'b0001;
      r_addr      <= '0;
      r_hit       <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_bottom <= w_at_bottom;
      if (w_step) begin
        {r_dir_x_neg, r_x} <= w_x_next;
        {r_dir_y_neg, r_y} <= w_y_next;
      end
      r_cnt   <= w_cnt_d;
      r_sel   <= w_sel_d;
      r_addr  <= w_addr;
      r_hit   <= w_hit;
      r_valid <= r_hit;
    end
  end

  assign rom_addr_o     = r_addr;
  assign sprite_valid_o = r_valid;
  assign image_sel_o    = r_sel;
  assign sprite_x_o     = r_x;
  assign sprite_y_o     = r_y;

endmodule
